// File: rtl/md_pkg.sv
// Shared decode constants, FSM state type and instruction classifiers for the
// HI/LO multiply/divide issue controller.
package md_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUED = 2'd1,
        BUSY   = 2'd2
    } md_state_e;

    typedef enum logic {
        CLS_START = 1'b0,
        CLS_HILO  = 1'b1
    } md_class_e;

    function automatic logic is_md_start(input logic [31:0] instr);
        return (instr[31:26] == OP_SPECIAL) &&
               (instr[5:0] inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
    endfunction

    function automatic logic is_hilo(input logic [31:0] instr);
        return is_md_start(instr) ||
               ((instr[31:26] == OP_SPECIAL) &&
                (instr[5:0] inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO}));
    endfunction

endpackage

// File: rtl/md_decode.sv
// Combinational classifier: flags an instruction as either an MD start op or
// any HI/LO-class op, selected per instance.
module md_decode
    import md_pkg::*;
#(
    parameter md_class_e CLASS = CLS_START
) (
    input  logic [31:0] instr_i,
    output logic        match_o
);

    assign match_o = (CLASS == CLS_HILO) ? is_hilo(instr_i) : is_md_start(instr_i);

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/hazard controller for the HI/LO MD unit: single-cycle start, D-stage
// stall on HI/LO hazards, completed-op counter and sticky protocol error.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int ISSUE_TIMEOUT = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_d,
    input  logic [31:0]      instr_e,
    input  logic             e_valid,
    input  logic             flush_e,
    input  logic             md_busy,
    output logic             md_start,
    output logic             stall_d,
    output logic             md_err,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int               TMO_W    = (ISSUE_TIMEOUT > 1) ? $clog2(ISSUE_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ISSUE_TIMEOUT - 1);

    md_state_e        state_q;
    logic [TMO_W-1:0] tmo_q;
    logic             md_err_q;
    logic [CNT_W-1:0] done_cnt_q;

    logic start_e;
    logic hilo_d;
    logic e_req;

    md_decode #(.CLASS(CLS_START)) u_dec_e (
        .instr_i (instr_e),
        .match_o (start_e)
    );

    md_decode #(.CLASS(CLS_HILO)) u_dec_d (
        .instr_i (instr_d),
        .match_o (hilo_d)
    );

    assign e_req = start_e & e_valid & ~flush_e;

    // Start is confined to IDLE so a held E stage cannot issue the same op twice.
    assign md_start = (state_q == IDLE) & e_req & ~md_busy;
    assign stall_d  = hilo_d & (md_busy | md_start | (state_q == ISSUED));
    assign md_err   = md_err_q;
    assign done_cnt = done_cnt_q;

    // NOTE: state uses non-blocking assignments and a synchronous reset test inside
    // the clocked block, so every register updates together on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            md_err_q   <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tmo_q <= '0;
                    if (md_start) begin
                        state_q <= ISSUED;
                    end else if (e_req && md_busy) begin
                        md_err_q <= 1'b1;
                    end
                end
                ISSUED: begin
                    if (md_busy) begin
                        state_q <= BUSY;
                    end else if (tmo_q == TMO_LAST) begin
                        md_err_q <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                BUSY: begin
                    if (!md_busy) begin
                        done_cnt_q <= done_cnt_q + 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
